mmio_timer: RTL and testbench
=============================

# mmio_timer

Memory-mapped timer peripheral on the data-memory port of the pipelined MIPS core. It decodes the core's MEM-stage access (`memwrite`, `memaddr`, `memwritedata`) and returns register contents on `memreaddata` in the same cycle. Reads and writes never stall the core. It provides a prescaled 32-bit up-counter, a compare match, a sticky match flag and an interrupt line. The top level muxes its `memreaddata` with data memory using `hit`.

## Interface
- `BASE_ADDR`, default 32'h0000_7F00: word-aligned base of the 32-byte register window.
- `PRESCALE_W`, default 16: width of the prescaler register and the prescaler counter.

- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `memwrite` input 1: store strobe from the MEM stage.
- `memaddr` input 32: byte address from the MEM stage; bits [1:0] are ignored.
- `memwritedata` input 32: store data.
- `memreaddata` output 32: read data. Combinational; 0 when `hit`=0.
- `hit` output 1: `memaddr[31:5]` == `BASE_ADDR[31:5]`.
- `irq` output 1: `STATUS.match & CTRL.irqen`. Driven from registers only, so it is glitch-free.

## Operation
Register map (offset = `memaddr[4:2]`×4):
- 0x00 CTRL: bit0 `en`, bit1 `autoreload`, bit2 `irqen`. Other bits read 0.
- 0x04 PRESCALE: bits [PRESCALE_W-1:0], value P.
- 0x08 COUNT: 32-bit up-counter, read/write.
- 0x0C COMPARE: 32-bit.
- 0x10 STATUS: bit0 `match`. Writing 1 clears the bit; writing 0 has no effect.
- 0x14–0x1C: read 0, writes ignored.

All of the following reset to 0: every register, the prescaler counter, and the FSM (STOPPED). The resulting outputs after reset are `irq`=0 and `hit`/`memreaddata` following the address inputs.

FSM states:
- STOPPED:
  - Write CTRL with `en`=1 → RUNNING, prescaler counter ← 0.
- RUNNING:
  - A tick occurs when the prescaler counter equals P. On a tick the counter returns to 0; otherwise it increments.
  - On a tick with COUNT==COMPARE: set `match`.
    - `autoreload`=1: COUNT ← 0, stay in RUNNING.
    - Otherwise: go to EXPIRED, COUNT holds.
  - On a tick without a match: COUNT ← COUNT+1, wrapping from 0xFFFF_FFFF to 0 with no flag.
  - Write CTRL with `en`=0 → STOPPED.
- EXPIRED:
  - Counting is frozen. CTRL.`en` still reads 1.
  - Write CTRL with `en`=1 → RUNNING, prescaler counter ← 0.
  - Write CTRL with `en`=0 → STOPPED.

Simultaneous events:
- A write to COUNT in the same cycle as a tick: the written value wins and the prescaler counter ← 0.
- A STATUS write-1 in the same cycle as a match set: the set wins.
- A write to PRESCALE while RUNNING takes effect at the next comparison. If the prescaler counter already exceeds the new P, it continues to wrap at 2^PRESCALE_W.
- A write to COMPARE takes effect on the next tick.
- Asserting `reset` mid-count returns everything to the reset values immediately, without waiting for a clock edge.

## Timing
- Register writes take effect at the rising edge that ends the MEM cycle.
- Reads are zero-latency combinational; a read in the cycle after a write returns the new value.
- With prescale value P, COUNT advances once every P+1 cycles. P=0 means one increment per cycle.
- Example: enable written at edge E with P=0 and COUNT=0. COUNT equals k after edge E+k. With COMPARE=N, `match` (and `irq` if enabled) asserts after edge E+N+1.
- `irq` rises in the same cycle that `match` becomes 1, and falls in the cycle after the write-1-to-clear edge.

## Configuration
- `TIMER_AUTORELOAD_EN` defined: CTRL bit1 is implemented as described above.
- Not defined:
  - CTRL bit1 is not stored and reads 0.
  - Every match goes to EXPIRED (one-shot only).
  - All other behaviour is identical.

## Test plan
- Reset: assert `reset` asynchronously mid-cycle → `irq`=0 immediately; reading 0x7F00–0x7F10 returns 0.
- One-shot: P=0, COMPARE=5, write CTRL=0x5 → `irq`=1 after the 6th edge following the enable write; COUNT reads 5 and holds for 20 more cycles.
- Prescale and wrap: P=3, COUNT=0xFFFF_FFFE, COMPARE=2, CTRL=0x1 → COUNT=0xFFFF_FFFF at +4 cycles, 0 at +8, 1 at +12, 2 at +16; `match`=1 at +20; no flag set at the wrap.
- Autoreload (with the macro): P=0, COMPARE=3, CTRL=0x7 → `match` sets after 4 cycles, COUNT=0, counting continues. A STATUS write of 1 in the next match cycle leaves `match`=1. Without the macro, CTRL reads 0x5 and the timer stops at 3.
- Collision: write COUNT=0x100 on a tick edge → COUNT reads 0x100, and the next increment occurs P+1 cycles later.
- Decode: a write to 0x7F20 or a read of 0x7F18 → `hit`=0 for 0x7F20; register state unchanged; 0x7F18 returns 0.

Source files
------------

// File: rtl/mmio_timer.sv
// Memory-mapped prescaled 32-bit timer with compare match, sticky flag and irq.
// Define TIMER_AUTORELOAD_EN to implement CTRL.autoreload; otherwise every match is one-shot.
module mmio_timer #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_7F00,
  parameter int          PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] memaddr,
  input  logic [31:0] memwritedata,
  output logic [31:0] memreaddata,
  output logic        hit,
  output logic        irq
);

  typedef enum logic [1:0] {STOPPED, RUNNING, EXPIRED} state_t;

  state_t                  state_q, state_d;
  logic                    en_q, en_d;
  logic                    irqen_q, irqen_d;
  logic                    match_q, match_d;
  logic [PRESCALE_W-1:0]   presc_q, presc_d;
  logic [PRESCALE_W-1:0]   pcnt_q, pcnt_d;
  logic [31:0]             count_q, count_d;
  logic [31:0]             compare_q, compare_d;
  logic                    autoreload;

  logic [2:0]  sel;
  logic        wr;
  logic        tick;
  logic        cmp_hit;
  logic [31:0] presc_ext;
  logic [31:0] rdata;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = ^memaddr[1:0];

`ifdef TIMER_AUTORELOAD_EN
  logic ar_q, ar_d;
  assign autoreload = ar_q;
`else
  assign autoreload = 1'b0;
`endif

  assign hit = (memaddr[31:5] == BASE_ADDR[31:5]);
  assign sel = memaddr[4:2];
  assign wr  = memwrite & hit;
  assign irq = match_q & irqen_q;

  // A tick can only happen while running; the compare value is sampled on the tick itself.
  assign tick    = (state_q == RUNNING) && (pcnt_q == presc_q);
  assign cmp_hit = tick && (count_q == compare_q);

  always_comb begin
    presc_ext                 = '0;
    presc_ext[PRESCALE_W-1:0] = presc_q;
    rdata                     = '0;
    case (sel)
      3'd0: rdata = {29'b0, irqen_q, autoreload, en_q};
      3'd1: rdata = presc_ext;
      3'd2: rdata = count_q;
      3'd3: rdata = compare_q;
      3'd4: rdata = {31'b0, match_q};
      default: rdata = '0;
    endcase
    memreaddata = hit ? rdata : 32'd0;
  end

  always_comb begin
    state_d   = state_q;
    en_d      = en_q;
    irqen_d   = irqen_q;
    match_d   = match_q;
    presc_d   = presc_q;
    pcnt_d    = pcnt_q;
    count_d   = count_q;
    compare_d = compare_q;
`ifdef TIMER_AUTORELOAD_EN
    ar_d      = ar_q;
`endif

    if (state_q == RUNNING) begin
      pcnt_d = tick ? '0 : pcnt_q + 1'b1;
    end

    if (tick) begin
      if (cmp_hit) begin
        if (autoreload) begin
          count_d = 32'd0;
        end else begin
          state_d = EXPIRED;
        end
      end else begin
        count_d = count_q + 32'd1;
      end
    end

    if (wr && sel == 3'd4 && memwritedata[0]) begin
      match_d = 1'b0;
    end
    // Setting the flag outranks a simultaneous software clear.
    if (cmp_hit) begin
      match_d = 1'b1;
    end

    if (wr) begin
      case (sel)
        3'd0: begin
          en_d    = memwritedata[0];
          irqen_d = memwritedata[2];
`ifdef TIMER_AUTORELOAD_EN
          ar_d    = memwritedata[1];
`endif
          if (memwritedata[0]) begin
            if (state_q != RUNNING) begin
              state_d = RUNNING;
              pcnt_d  = '0;
            end
          end else begin
            state_d = STOPPED;
          end
        end
        3'd1: presc_d   = memwritedata[PRESCALE_W-1:0];
        3'd2: count_d   = memwritedata;
        3'd3: compare_d = memwritedata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= STOPPED;
      en_q      <= 1'b0;
      irqen_q   <= 1'b0;
      match_q   <= 1'b0;
      presc_q   <= '0;
      pcnt_q    <= '0;
      count_q   <= 32'd0;
      compare_q <= 32'd0;
`ifdef TIMER_AUTORELOAD_EN
      ar_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      irqen_q   <= irqen_d;
      match_q   <= match_d;
      presc_q   <= presc_d;
      pcnt_q    <= pcnt_d;
      count_q   <= count_d;
      compare_q <= compare_d;
`ifdef TIMER_AUTORELOAD_EN
      ar_q      <= ar_d;
`endif
    end
  end

endmodule

// File: tb/tb_mmio_timer.sv
// Self-checking bench for mmio_timer: directed scenarios plus randomized one-shot runs
// whose expected COUNT/match timeline is computed in closed form from P, start and compare.
module tb_mmio_timer;

  localparam logic [31:0] A_CTRL  = 32'h0000_7F00;
  localparam logic [31:0] A_PRESC = 32'h0000_7F04;
  localparam logic [31:0] A_COUNT = 32'h0000_7F08;
  localparam logic [31:0] A_CMP   = 32'h0000_7F0C;
  localparam logic [31:0] A_STAT  = 32'h0000_7F10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memwrite = 1'b0;
  logic [31:0] memaddr = A_CTRL;
  logic [31:0] memwritedata = 32'd0;
  logic [31:0] memreaddata;
  logic        hit;
  logic        irq;

  int checks = 0;
  int errors = 0;

  mmio_timer dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .memaddr(memaddr),
    .memwritedata(memwritedata), .memreaddata(memreaddata), .hit(hit), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    memaddr = a;
    #1;
    d = memreaddata;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    memaddr      = a;
    memwritedata = d;
    memwrite     = 1'b1;
    @(posedge clk);
    #1;
    memwrite = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-shot run: COUNT = c + floor(m/(P+1)) capped at the compare distance, match from edge (d+1)(P+1).
  task automatic run_trial(input int p, input logic [31:0] c, input logic [31:0] n,
                           input bit ie, input int extra);
    logic [31:0] v;
    int d, per, medge, k;
    logic exp_m;
    wr(A_CTRL, 32'd0);
    wr(A_STAT, 32'd1);
    wr(A_PRESC, 32'(p));
    wr(A_COUNT, c);
    wr(A_CMP, n);
    wr(A_CTRL, {29'b0, ie, 1'b0, 1'b1});
    d     = int'(n - c);
    per   = p + 1;
    medge = (d + 1) * per;
    rd(A_CTRL, v);  chk("trial_ctrl", v, {29'b0, ie, 2'b01});
    rd(A_COUNT, v); chk("trial_count_start", v, c);
    rd(A_STAT, v);  chk("trial_match_start", v, 32'd0);
    for (int m = 1; m <= medge + extra; m++) begin
      cyc(1);
      k = m / per;
      if (k > d) k = d;
      exp_m = (m >= medge);
      rd(A_COUNT, v); chk($sformatf("trial_count p=%0d m=%0d", p, m), v, c + 32'(k));
      rd(A_STAT, v);  chk($sformatf("trial_match p=%0d m=%0d", p, m), v, {31'b0, exp_m});
      chk($sformatf("trial_irq m=%0d", m), {31'b0, irq}, {31'b0, exp_m & ie});
    end
    rd(A_CTRL, v); chk("trial_ctrl_expired_en", v, {29'b0, ie, 2'b01});
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] c;

    // Reset state while reset is held
    #2;
    chk("rst_irq", {31'b0, irq}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      rd(A_CTRL + 32'(4 * i), v);
      chk($sformatf("rst_reg%0d", i), v, 32'd0);
      chk($sformatf("rst_hit%0d", i), {31'b0, hit}, 32'd1);
    end
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk); #1;

    // Decode and register readback
    wr(A_CMP, 32'h0000_1234);
    memaddr = 32'h0000_7F20;
    #1;
    chk("dec_hit_7f20", {31'b0, hit}, 32'd0);
    chk("dec_rd_7f20", memreaddata, 32'd0);
    wr(32'h0000_7F20, 32'h0000_0005);
    wr(32'h0000_7F28, 32'h0000_0055);
    wr(32'h0000_7F18, 32'hFFFF_FFFF);
    rd(32'h0000_7F18, v);
    chk("dec_rd_7f18", v, 32'd0);
    chk("dec_hit_7f18", {31'b0, hit}, 32'd1);
    cyc(3);
    rd(A_CTRL, v);  chk("dec_ctrl", v, 32'd0);
    rd(A_COUNT, v); chk("dec_count", v, 32'd0);
    rd(A_CMP, v);   chk("dec_cmp", v, 32'h0000_1234);
    wr(A_PRESC, 32'hFFFF_FFFF);
    rd(A_PRESC, v); chk("presc_width", v, 32'h0000_FFFF);

    // One-shot: P=0, COMPARE=5, irq enabled, then hold for 20 cycles
    run_trial(0, 32'd0, 32'd5, 1'b1, 20);

    // Asynchronous reset mid-count
    wr(A_COUNT, 32'd0);
    wr(A_CTRL, 32'h5);
    cyc(2);
    rd(A_COUNT, v); chk("premid_count", v, 32'd2);
    chk("premid_irq", {31'b0, irq}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_irq", {31'b0, irq}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      rd(A_CTRL + 32'(4 * i), v);
      chk($sformatf("midrst_reg%0d", i), v, 32'd0);
    end
    @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk); #1;
    cyc(3);
    rd(A_COUNT, v); chk("postrst_count", v, 32'd0);

    // Prescale and wrap through 0xFFFF_FFFF without a flag
    run_trial(3, 32'hFFFF_FFFE, 32'd2, 1'b0, 3);

    // COUNT write colliding with a tick
    wr(A_CTRL, 32'd0);
    wr(A_STAT, 32'd1);
    wr(A_PRESC, 32'd3);
    wr(A_COUNT, 32'd0);
    wr(A_CMP, 32'h0000_FFFF);
    wr(A_CTRL, 32'h1);
    cyc(7);
    rd(A_COUNT, v); chk("coll_before", v, 32'd1);
    wr(A_COUNT, 32'h100);
    rd(A_COUNT, v); chk("coll_written", v, 32'h100);
    cyc(3);
    rd(A_COUNT, v); chk("coll_hold", v, 32'h100);
    cyc(1);
    rd(A_COUNT, v); chk("coll_next", v, 32'h101);

    // Autoreload / one-shot fallback
    wr(A_CTRL, 32'd0);
    wr(A_STAT, 32'd1);
    wr(A_PRESC, 32'd0);
    wr(A_COUNT, 32'd0);
    wr(A_CMP, 32'd3);
    wr(A_CTRL, 32'h7);
`ifdef TIMER_AUTORELOAD_EN
    rd(A_CTRL, v);  chk("ar_ctrl", v, 32'h7);
    cyc(4);
    rd(A_STAT, v);  chk("ar_match", v, 32'd1);
    rd(A_COUNT, v); chk("ar_reload", v, 32'd0);
    cyc(3);
    rd(A_COUNT, v); chk("ar_count3", v, 32'd3);
    wr(A_STAT, 32'd1);
    rd(A_STAT, v);  chk("ar_set_wins", v, 32'd1);
    rd(A_COUNT, v); chk("ar_reload2", v, 32'd0);
    wr(A_STAT, 32'd1);
    rd(A_STAT, v);  chk("ar_cleared", v, 32'd0);
    rd(A_COUNT, v); chk("ar_count1", v, 32'd1);
`else
    rd(A_CTRL, v);  chk("os_ctrl", v, 32'h5);
    cyc(4);
    rd(A_STAT, v);  chk("os_match", v, 32'd1);
    rd(A_COUNT, v); chk("os_count", v, 32'd3);
    cyc(5);
    rd(A_COUNT, v); chk("os_hold", v, 32'd3);
    chk("os_irq", {31'b0, irq}, 32'd1);
    wr(A_STAT, 32'd1);
    chk("os_irq_clear", {31'b0, irq}, 32'd0);
`endif

    // Randomized one-shot runs
    for (int t = 0; t < 6; t++) begin
      c = $urandom;
      run_trial(int'($urandom_range(0, 3)), c, c + 32'($urandom_range(0, 5)),
                1'($urandom_range(0, 1)), 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
